br_predictor_gshare: RTL



---
 rtl/br_predictor_gshare.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/br_predictor_gshare.sv
// Gshare fetch predictor: direct-mapped typed BTB, PC^GHR indexed PHT, circular RAS.
// Define BR_PRED_STATS_EN to add lookup/hit/mispredict statistics counters.
module br_predictor_gshare #(
    parameter int PC_W      = 64,
    parameter int BTB_IDX_W = 6,
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int RAS_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_pc_valid,
    input  logic [PC_W-1:0]  io_pc,
    output logic             io_pre_valid,
    output logic [PC_W-1:0]  io_pre_next_pc,
    output logic [GHR_W-1:0] io_pre_ghr,
    input  logic             io_br_info_valid,
    input  logic             io_br_info_mispredict,
    input  logic [PC_W-1:0]  io_br_info_br_pc,
    input  logic             io_br_info_taken,
    input  logic [PC_W-1:0]  io_br_info_target_next_pc,
    input  logic [1:0]       io_br_info_br_type,
    input  logic [GHR_W-1:0] io_br_info_ghr
`ifdef BR_PRED_STATS_EN
    ,
    output logic [31:0]      io_stat_lookup,
    output logic [31:0]      io_stat_hit,
    output logic [31:0]      io_stat_mispredict
`endif
);

    localparam int BTB_N     = 1 << BTB_IDX_W;
    localparam int PHT_N     = 1 << PHT_IDX_W;
    localparam int TAG_W     = PC_W - BTB_IDX_W - 2;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    localparam logic [1:0] T_COND = 2'd0;
    localparam logic [1:0] T_CALL = 2'd1;
    localparam logic [1:0] T_RET  = 2'd2;

    logic                 btb_valid  [BTB_N];
    logic [TAG_W-1:0]     btb_tag    [BTB_N];
    logic [PC_W-1:0]      btb_target [BTB_N];
    logic [1:0]           btb_type   [BTB_N];
    logic [1:0]           pht        [PHT_N];
    logic [PC_W-1:0]      ras        [RAS_DEPTH];
    logic [GHR_W-1:0]     ghr;
    logic [RAS_PTR_W-1:0] ras_head;
    logic [RAS_CNT_W-1:0] ras_count;

    // Lookup side
    logic [BTB_IDX_W-1:0] lk_bidx;
    logic [TAG_W-1:0]     lk_tag;
    logic [PHT_IDX_W-1:0] lk_pidx;
    logic                 lk_hit;
    logic [1:0]           lk_type;
    logic                 lk_dir;
    logic                 pred_taken;
    logic [RAS_PTR_W-1:0] ras_top_idx;
    logic                 ras_nonempty;

    // Update side
    logic [BTB_IDX_W-1:0] up_bidx;
    logic [TAG_W-1:0]     up_tag;
    logic [PHT_IDX_W-1:0] up_pidx;
    logic                 repair;
    logic                 btb_wr;
    logic                 pht_wr;

    logic                 ras_push;
    logic                 ras_pop;

    logic                 unused_pc_bits;
    assign unused_pc_bits = ^{io_pc[1:0], io_br_info_br_pc[1:0]};

    assign lk_bidx      = io_pc[BTB_IDX_W+2:3];
    assign lk_tag       = {io_pc[PC_W-1:BTB_IDX_W+3], io_pc[2]};
    assign lk_pidx      = io_pc[PHT_IDX_W+2:3] ^ PHT_IDX_W'(ghr);
    assign lk_hit       = io_pc_valid & ~reset & btb_valid[lk_bidx] & (btb_tag[lk_bidx] == lk_tag);
    assign lk_type      = btb_type[lk_bidx];
    assign lk_dir       = pht[lk_pidx][1];
    assign pred_taken   = lk_hit & ((lk_type != T_COND) | lk_dir);
    assign ras_top_idx  = ras_head - RAS_PTR_W'(1);
    assign ras_nonempty = (ras_count != '0);

    assign up_bidx = io_br_info_br_pc[BTB_IDX_W+2:3];
    assign up_tag  = {io_br_info_br_pc[PC_W-1:BTB_IDX_W+3], io_br_info_br_pc[2]};
    assign up_pidx = io_br_info_br_pc[PHT_IDX_W+2:3] ^ PHT_IDX_W'(io_br_info_ghr);
    assign repair  = ~reset & io_br_info_valid & io_br_info_mispredict;
    assign btb_wr  = repair & io_br_info_taken;
    assign pht_wr  = ~reset & io_br_info_valid & (io_br_info_br_type == T_COND);

    // A resolved mispredict discards this cycle's speculative RAS activity.
    assign ras_push = pred_taken & ~repair & (lk_type == T_CALL);
    assign ras_pop  = pred_taken & ~repair & (lk_type == T_RET) & ras_nonempty;

    always_comb begin
        io_pre_valid   = pred_taken;
        io_pre_next_pc = '0;
        io_pre_ghr     = ghr;
        if (pred_taken) begin
            if ((lk_type == T_RET) && ras_nonempty) begin
                io_pre_next_pc = ras[ras_top_idx];
            end else begin
                io_pre_next_pc = btb_target[lk_bidx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
        end else if (btb_wr) begin
            btb_valid[up_bidx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (btb_wr) begin
            btb_tag[up_bidx]    <= up_tag;
            btb_target[up_bidx] <= io_br_info_target_next_pc;
            btb_type[up_bidx]   <= io_br_info_br_type;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b10;
        end else if (pht_wr) begin
            if (io_br_info_taken && (pht[up_pidx] != 2'b11)) begin
                pht[up_pidx] <= pht[up_pidx] + 2'b01;
            end else if (!io_br_info_taken && (pht[up_pidx] != 2'b00)) begin
                pht[up_pidx] <= pht[up_pidx] - 2'b01;
            end
        end
    end

    // Repair wins over the speculative shift from a same-cycle lookup.
    always_ff @(posedge clock) begin
        if (reset) begin
            ghr <= '0;
        end else if (repair) begin
            if (io_br_info_br_type == T_COND) begin
                ghr <= {io_br_info_ghr[GHR_W-2:0], io_br_info_taken};
            end else begin
                ghr <= io_br_info_ghr;
            end
        end else if (lk_hit && (lk_type == T_COND)) begin
            ghr <= {ghr[GHR_W-2:0], lk_dir};
        end
    end

    // A push into a full stack overwrites the oldest entry; count saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            ras_head  <= '0;
            ras_count <= '0;
        end else if (ras_push) begin
            ras_head <= ras_head + RAS_PTR_W'(1);
            if (ras_count != RAS_CNT_W'(RAS_DEPTH)) begin
                ras_count <= ras_count + RAS_CNT_W'(1);
            end
        end else if (ras_pop) begin
            ras_head  <= ras_top_idx;
            ras_count <= ras_count - RAS_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (ras_push) begin
            ras[ras_head] <= io_pc + PC_W'(4);
        end
    end

`ifdef BR_PRED_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            io_stat_lookup     <= '0;
            io_stat_hit        <= '0;
            io_stat_mispredict <= '0;
        end else begin
            if (io_pc_valid) io_stat_lookup <= io_stat_lookup + 32'd1;
            if (pred_taken)  io_stat_hit    <= io_stat_hit + 32'd1;
            if (repair)      io_stat_mispredict <= io_stat_mispredict + 32'd1;
        end
    end
`endif

endmodule
